// File: rtl/if_fetch.sv
// if_fetch: PC owner, ROM fetch and 2-entry fetch queue with decode handshake and branch redirect.
// Optional IF_PERF_EN adds a saturating full-queue stall counter on perf_stall_cnt.
module if_fetch #(
   parameter int                 ADDR_W   = 64,
   parameter int                 INST_W   = 64,
   parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   output logic              rom_ce,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [INST_W-1:0] rom_inst,
   input  logic              br_flag,
   input  logic [ADDR_W-1:0] br_target,
   output logic              id_valid,
   input  logic              id_ready,
   output logic [ADDR_W-1:0] id_pc,
   output logic [INST_W-1:0] id_inst
`ifdef IF_PERF_EN
  ,output logic [31:0]       perf_stall_cnt
`endif
);
   typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;
   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d, h_pc_q, h_pc_d, t_pc_q, t_pc_d;
   logic [INST_W-1:0] h_inst_q, h_inst_d, t_inst_q, t_inst_d;
   logic [1:0]        cnt_q, cnt_d;
   logic              active, pop, push, stall;
   always_comb begin
      active   = state_q != IDLE;
      pop      = (cnt_q != 2'd0) & id_ready;
      push     = active & ~br_flag & ((cnt_q != 2'd2) | pop);
      stall    = active & ~br_flag & (cnt_q == 2'd2) & ~pop;
      state_d  = (push | ~active | br_flag) ? FETCH : HOLD;
      pc_d     = br_flag ? (br_target & ~ADDR_W'(15)) : push ? pc_q + ADDR_W'(16) : pc_q;
      cnt_d    = br_flag ? 2'd0 : cnt_q + {1'b0, push} - {1'b0, pop};
      h_pc_d   = h_pc_q;
      h_inst_d = h_inst_q;
      t_pc_d   = t_pc_q;
      t_inst_d = t_inst_q;
      if (pop) begin
         h_pc_d   = t_pc_q;
         h_inst_d = t_inst_q;
      end
      // New entry lands in the first slot left free after this cycle's pop.
      if (push && (cnt_q - {1'b0, pop}) == 2'd0) begin
         h_pc_d   = pc_q;
         h_inst_d = rom_inst;
      end else if (push) begin
         t_pc_d   = pc_q;
         t_inst_d = rom_inst;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         pc_q     <= RESET_PC;
         cnt_q    <= 2'd0;
         h_pc_q   <= '0;
         h_inst_q <= '0;
         t_pc_q   <= '0;
         t_inst_q <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         cnt_q    <= cnt_d;
         h_pc_q   <= h_pc_d;
         h_inst_q <= h_inst_d;
         t_pc_q   <= t_pc_d;
         t_inst_q <= t_inst_d;
      end
   end
   assign rom_ce   = active;
   assign rom_addr = pc_q;
   assign id_valid = cnt_q != 2'd0;
   assign id_pc    = id_valid ? h_pc_q : '0;
   assign id_inst  = id_valid ? h_inst_q : '0;
`ifdef IF_PERF_EN
   logic [31:0] stall_q;
   always_ff @(posedge clk) begin
      if (rst) stall_q <= '0;
      else if (stall && stall_q != 32'hFFFF_FFFF) stall_q <= stall_q + 32'd1;
   end
   assign perf_stall_cnt = stall_q;
`endif
endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: random + directed stimulus checked each cycle against a queue-based model of if_fetch.
module tb_if_fetch;
   logic        clk = 0;
   logic        rst = 1;
   logic        rom_ce;
   logic [63:0] rom_addr;
   logic [63:0] rom_inst;
   logic        br_flag = 0;
   logic [63:0] br_target = '0;
   logic        id_valid;
   logic        id_ready = 0;
   logic [63:0] id_pc;
   logic [63:0] id_inst;
`ifdef IF_PERF_EN
   logic [31:0] perf_stall_cnt;
`endif
   int total = 0;
   int bad = 0;
   typedef struct {logic [63:0] pc; logic [63:0] inst;} ent_t;
   ent_t        m_q[$];
   logic [63:0] m_pc = '0;
   bit          m_started = 0;
   logic [31:0] m_stall = '0;

   always #5 clk = ~clk;

   function automatic logic [63:0] rom_fn(input logic [63:0] a);
      return (a * 64'h9E37_79B9_7F4A_7C15) ^ 64'hDEAD_BEEF_0BAD_F00D;
   endfunction
   assign rom_inst = rom_fn(rom_addr);

   if_fetch dut (
      .clk(clk), .rst(rst), .rom_ce(rom_ce), .rom_addr(rom_addr), .rom_inst(rom_inst),
      .br_flag(br_flag), .br_target(br_target), .id_valid(id_valid), .id_ready(id_ready),
      .id_pc(id_pc), .id_inst(id_inst)
`ifdef IF_PERF_EN
     ,.perf_stall_cnt(perf_stall_cnt)
`endif
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // One cycle: compare DUT against model, drive inputs, advance model across the coming edge.
   task automatic step(input bit r, input bit b, input logic [63:0] t, input bit rd);
      bit pop;
      @(negedge clk);
      chk("rom_ce", {63'b0, rom_ce}, {63'b0, m_started});
      if (m_started) chk("rom_addr", rom_addr, m_pc);
      chk("id_valid", {63'b0, id_valid}, {63'b0, m_q.size() != 0});
      chk("id_pc", id_pc, m_q.size() != 0 ? m_q[0].pc : 64'd0);
      chk("id_inst", id_inst, m_q.size() != 0 ? m_q[0].inst : 64'd0);
`ifdef IF_PERF_EN
      chk("perf", {32'b0, perf_stall_cnt}, {32'b0, m_stall});
`endif
      rst = r; br_flag = b; br_target = t; id_ready = rd;
      pop = m_q.size() != 0 && rd;
      if (r) begin
         m_started = 0; m_pc = '0; m_q.delete(); m_stall = '0;
      end else if (b) begin
         m_q.delete(); m_pc = {t[63:4], 4'b0}; m_started = 1;
      end else if (!m_started) begin
         m_started = 1;
      end else begin
         if (pop) void'(m_q.pop_front());
         if (m_q.size() < 2) begin
            m_q.push_back('{m_pc, rom_fn(m_pc)});
            m_pc = m_pc + 64'd16;
         end else if (m_stall != 32'hFFFF_FFFF) m_stall++;
      end
   endtask

   initial begin
      step(1, 0, 0, 1); step(1, 0, 0, 1);
      step(0, 0, 0, 1); chk("c0_ce", {63'b0, rom_ce}, 64'd0);
      step(0, 0, 0, 1); chk("c1_ce", {63'b0, rom_ce}, 64'd1); chk("c1_addr", rom_addr, 64'h0);
      step(0, 0, 0, 1); chk("c2_valid", {63'b0, id_valid}, 64'd1); chk("c2_pc", id_pc, 64'h00);
      step(0, 0, 0, 1); chk("c3_pc", id_pc, 64'h10);
      step(0, 0, 0, 1); chk("c4_pc", id_pc, 64'h20);
      step(0, 0, 0, 1); chk("c5_pc", id_pc, 64'h30);
      step(1, 0, 0, 1);
      step(0, 0, 0, 1); step(0, 0, 0, 1);
      for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
      step(0, 0, 0, 1);
      chk("bp_pc", id_pc, 64'h00); chk("bp_addr", rom_addr, 64'h20);
`ifdef IF_PERF_EN
      chk("bp_perf", {32'b0, perf_stall_cnt}, 64'd4);
`endif
      step(0, 0, 0, 1); chk("bp_pc1", id_pc, 64'h10);
      step(0, 0, 0, 0); chk("bp_pc2", id_pc, 64'h20);
      step(0, 0, 0, 0);
      step(0, 1, 64'h1237, 0);
      step(0, 0, 0, 1); chk("br_valid", {63'b0, id_valid}, 64'd0); chk("br_addr", rom_addr, 64'h1230);
      step(0, 0, 0, 1); chk("br_pc0", id_pc, 64'h1230);
      step(0, 0, 0, 1); chk("br_pc1", id_pc, 64'h1240);
      step(0, 1, 64'hFFFF_FFFF_FFFF_FFF5, 1);
      step(0, 0, 0, 1); chk("wrap_a0", rom_addr, 64'hFFFF_FFFF_FFFF_FFF0);
      step(0, 0, 0, 1); chk("wrap_a1", rom_addr, 64'h0); chk("wrap_pc", id_pc, 64'hFFFF_FFFF_FFFF_FFF0);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
      step(1, 0, 0, 0);
      step(0, 0, 0, 1); chk("rp_valid", {63'b0, id_valid}, 64'd0); chk("rp_ce", {63'b0, rom_ce}, 64'd0);
      step(0, 0, 0, 1); chk("rp_addr", rom_addr, 64'h0);
      step(0, 0, 0, 1); chk("rp_pc", id_pc, 64'h0);
      for (int i = 0; i < 3000; i++) begin
         logic [63:0] t;
         t = {$urandom, $urandom};
         if ($urandom_range(0, 7) == 0) t = 64'hFFFF_FFFF_FFFF_FFC0 | 64'($urandom_range(0, 63));
         step($urandom_range(0, 59) == 0, $urandom_range(0, 11) == 0, t, $urandom_range(0, 9) < 6);
      end
      step(0, 0, 0, 1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
